// File: rtl/cv32e40s_rvfi_pkg.sv
// Shared types for the RVFI data-side OBI tracker.
// The entry fields are sized by the package widths; module ADDR/DATA widths must not exceed them.
package cv32e40s_rvfi_pkg;

  localparam int OBI_ADDR_WIDTH = 32;
  localparam int OBI_DATA_WIDTH = 32;
  localparam int OBI_BE_WIDTH   = OBI_DATA_WIDTH / 8;

  typedef struct packed {
    logic [OBI_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [OBI_BE_WIDTH-1:0]   be;
    logic [OBI_DATA_WIDTH-1:0] wdata;
    logic [OBI_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      resp_done;
  } obi_data_entry_t;

endpackage

// File: rtl/cv32e40s_rvfi_obi_ring.sv
// Circular buffer of OBI transactions with write, response and retire pointers.
// Presents the MAX_BEATS oldest entries, with the current response forwarded in.
module cv32e40s_rvfi_obi_ring
  import cv32e40s_rvfi_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_BEATS  = 2,
  parameter int ADDR_WIDTH = OBI_ADDR_WIDTH,
  parameter int DATA_WIDTH = OBI_DATA_WIDTH,
  localparam int PTR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic                    push_we,
  input  logic [DATA_WIDTH/8-1:0] push_be,
  input  logic [DATA_WIDTH-1:0]   push_wdata,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    rsp_err,
  input  logic [CNT_WIDTH-1:0]    retire_cnt,
  output obi_data_entry_t         beat_entry [MAX_BEATS],
  output logic                    push_drop,
  output logic                    rsp_drop
);

  obi_data_entry_t      mem [DEPTH];
  obi_data_entry_t      push_entry;
  logic [PTR_WIDTH:0]   wptr_reg;
  logic [PTR_WIDTH:0]   rsp_ptr_reg;
  logic [PTR_WIDTH:0]   rptr_reg;
  logic [PTR_WIDTH:0]   occ;
  logic                 full;
  logic                 rsp_ok;

  assign occ       = wptr_reg - rptr_reg;
  assign full      = (occ == (PTR_WIDTH + 1)'(DEPTH));
  assign push_drop = push && full;
  assign rsp_ok    = rsp_valid && (rsp_ptr_reg != wptr_reg);
  assign rsp_drop  = rsp_valid && (rsp_ptr_reg == wptr_reg);

  always_comb begin
    push_entry       = '0;
    push_entry.addr  = OBI_ADDR_WIDTH'(push_addr);
    push_entry.we    = push_we;
    push_entry.be    = OBI_BE_WIDTH'(push_be);
    push_entry.wdata = OBI_DATA_WIDTH'(push_wdata);
  end

  // Full is judged on pre-cycle occupancy: a same-cycle retire never makes room.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg    <= '0;
      rsp_ptr_reg <= '0;
      rptr_reg    <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr_reg[PTR_WIDTH-1:0]] <= push_entry;
        wptr_reg                     <= wptr_reg + 1'b1;
      end
      if (rsp_ok) begin
        mem[rsp_ptr_reg[PTR_WIDTH-1:0]].rdata     <= OBI_DATA_WIDTH'(rsp_rdata);
        mem[rsp_ptr_reg[PTR_WIDTH-1:0]].err       <= rsp_err;
        mem[rsp_ptr_reg[PTR_WIDTH-1:0]].resp_done <= 1'b1;
        rsp_ptr_reg                               <= rsp_ptr_reg + 1'b1;
      end
      rptr_reg <= rptr_reg + (PTR_WIDTH + 1)'(retire_cnt);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BEATS; gi++) begin : g_beat
      logic [PTR_WIDTH:0] idx;
      logic               in_occ;
      logic               fwd;
      obi_data_entry_t    view;

      assign idx    = rptr_reg + (PTR_WIDTH + 1)'(gi);
      assign in_occ = ((PTR_WIDTH + 1)'(gi) < occ);
      assign fwd    = rsp_ok && (idx == rsp_ptr_reg);

      // resp_done is only meaningful for live entries; stale slots read as incomplete.
      always_comb begin
        view = mem[idx[PTR_WIDTH-1:0]];
        if (fwd) begin
          view.rdata     = OBI_DATA_WIDTH'(rsp_rdata);
          view.err       = rsp_err;
          view.resp_done = 1'b1;
        end
        view.resp_done = view.resp_done && in_occ;
      end

      assign beat_entry[gi] = view;
    end
  endgenerate

endmodule

// File: rtl/cv32e40s_rvfi_data_obi_mb.sv
// Multi-beat RVFI data-OBI aligner: gathers a retiring instruction's OBI
// transactions from the ring and emits them as one registered record.
module cv32e40s_rvfi_data_obi_mb
  import cv32e40s_rvfi_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_BEATS  = 2,
  parameter int ADDR_WIDTH = OBI_ADDR_WIDTH,
  parameter int DATA_WIDTH = OBI_DATA_WIDTH,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            obi_req,
  input  logic                            obi_gnt,
  input  logic [ADDR_WIDTH-1:0]           obi_addr,
  input  logic                            obi_we,
  input  logic [BE_WIDTH-1:0]             obi_be,
  input  logic [DATA_WIDTH-1:0]           obi_wdata,
  input  logic                            obi_rvalid,
  input  logic [DATA_WIDTH-1:0]           obi_rdata,
  input  logic                            obi_err,
  input  logic                            wb_valid,
  input  logic [CNT_WIDTH-1:0]            wb_beats,
  output logic                            out_valid,
  output logic [CNT_WIDTH-1:0]            out_beats,
  output logic [MAX_BEATS*ADDR_WIDTH-1:0] out_addr,
  output logic [MAX_BEATS-1:0]            out_we,
  output logic [MAX_BEATS*BE_WIDTH-1:0]   out_be,
  output logic [MAX_BEATS*DATA_WIDTH-1:0] out_wdata,
  output logic [MAX_BEATS*DATA_WIDTH-1:0] out_rdata,
  output logic [MAX_BEATS-1:0]            out_err,
  output logic                            overflow,
  output logic                            underflow
);

  obi_data_entry_t                 beat_entry [MAX_BEATS];
  logic                            push_drop;
  logic                            rsp_drop;
  logic                            retire_fire;
  logic                            retire_short;
  logic [CNT_WIDTH-1:0]            adv_cnt;
  logic [CNT_WIDTH-1:0]            retire_cnt;
  logic [MAX_BEATS-1:0]            take;
  logic [MAX_BEATS-1:0]            we_next;
  logic [MAX_BEATS-1:0]            err_next;
  logic [MAX_BEATS*ADDR_WIDTH-1:0] addr_next;
  logic [MAX_BEATS*BE_WIDTH-1:0]   be_next;
  logic [MAX_BEATS*DATA_WIDTH-1:0] wdata_next;
  logic [MAX_BEATS*DATA_WIDTH-1:0] rdata_next;

  logic                            out_valid_reg;
  logic [CNT_WIDTH-1:0]            out_beats_reg;
  logic [MAX_BEATS*ADDR_WIDTH-1:0] out_addr_reg;
  logic [MAX_BEATS-1:0]            out_we_reg;
  logic [MAX_BEATS*BE_WIDTH-1:0]   out_be_reg;
  logic [MAX_BEATS*DATA_WIDTH-1:0] out_wdata_reg;
  logic [MAX_BEATS*DATA_WIDTH-1:0] out_rdata_reg;
  logic [MAX_BEATS-1:0]            out_err_reg;
  logic                            overflow_reg;
  logic                            underflow_reg;

  cv32e40s_rvfi_obi_ring #(
    .DEPTH      (DEPTH),
    .MAX_BEATS  (MAX_BEATS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .push       (obi_req && obi_gnt),
    .push_addr  (obi_addr),
    .push_we    (obi_we),
    .push_be    (obi_be),
    .push_wdata (obi_wdata),
    .rsp_valid  (obi_rvalid),
    .rsp_rdata  (obi_rdata),
    .rsp_err    (obi_err),
    .retire_cnt (retire_cnt),
    .beat_entry (beat_entry),
    .push_drop  (push_drop),
    .rsp_drop   (rsp_drop)
  );

  // Responses arrive in order, so the completed beats form a prefix from rptr.
  always_comb begin
    logic run;
    adv_cnt = '0;
    run     = 1'b1;
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (CNT_WIDTH'(i) < wb_beats) begin
        if (run && beat_entry[i].resp_done) begin
          adv_cnt = adv_cnt + CNT_WIDTH'(1);
        end else begin
          run = 1'b0;
        end
      end
    end
  end

  assign retire_fire  = wb_valid && (wb_beats != '0);
  assign retire_cnt   = retire_fire ? adv_cnt : '0;
  assign retire_short = retire_fire && (adv_cnt < wb_beats);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BEATS; gi++) begin : g_gather
      assign take[gi]     = (CNT_WIDTH'(gi) < adv_cnt);
      assign we_next[gi]  = take[gi] && beat_entry[gi].we;
      assign err_next[gi] = take[gi] && beat_entry[gi].err;
      assign addr_next[gi*ADDR_WIDTH +: ADDR_WIDTH] =
        take[gi] ? ADDR_WIDTH'(beat_entry[gi].addr) : '0;
      assign be_next[gi*BE_WIDTH +: BE_WIDTH] =
        take[gi] ? BE_WIDTH'(beat_entry[gi].be) : '0;
      assign wdata_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        take[gi] ? DATA_WIDTH'(beat_entry[gi].wdata) : '0;
      assign rdata_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        take[gi] ? DATA_WIDTH'(beat_entry[gi].rdata) : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_beats_reg <= '0;
      out_addr_reg  <= '0;
      out_we_reg    <= '0;
      out_be_reg    <= '0;
      out_wdata_reg <= '0;
      out_rdata_reg <= '0;
      out_err_reg   <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      out_valid_reg <= retire_fire;
      if (retire_fire) begin
        out_beats_reg <= wb_beats;
        out_addr_reg  <= addr_next;
        out_we_reg    <= we_next;
        out_be_reg    <= be_next;
        out_wdata_reg <= wdata_next;
        out_rdata_reg <= rdata_next;
        out_err_reg   <= err_next;
      end
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end
      if (rsp_drop || retire_short) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_beats = out_beats_reg;
  assign out_addr  = out_addr_reg;
  assign out_we    = out_we_reg;
  assign out_be    = out_be_reg;
  assign out_wdata = out_wdata_reg;
  assign out_rdata = out_rdata_reg;
  assign out_err   = out_err_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
